// File: rtl/matrix_pkg.sv
// Shared types and constants for the 2x2 matrix add/subtract sequencer.
package matrix_pkg;
  localparam int DATA_W    = 8;
  localparam int MAT_ELEMS = 4;
  localparam int IDX_W     = 2;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_A     = 3'd1,
    ST_WAIT_OP    = 3'd2,
    ST_LOAD_B     = 3'd3,
    ST_WAIT_ENTER = 3'd4,
    ST_EXEC       = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  function automatic logic is_valid_op(input logic [2:0] oc);
    return (oc == OP_ADD) || (oc == OP_SUB);
  endfunction
endpackage

// File: rtl/matrix_elem_alu.sv
// Combinational single-element signed add/subtract with overflow detection.
// Define MATOP_SATURATE_EN to clamp overflowed results instead of wrapping.
module matrix_elem_alu
  import matrix_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);
  logic [DATA_W-1:0] raw;

  always_comb begin
    raw = sub ? (a - b) : (a + b);
    // Overflow when the result sign disagrees with what the operand signs allow.
    if (sub)
      ovf = (a[DATA_W-1] != b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
    else
      ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
`ifdef MATOP_SATURATE_EN
    if (ovf)
      res = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      res = raw;
`else
    res = raw;
`endif
  end
endmodule

// File: rtl/matrix_op_sequencer.sv
// Keypad-driven 2x2 matrix add/subtract sequencer: load A, opcode, load B, enter,
// then stream four results. Saturation build option: MATOP_SATURATE_EN.
module matrix_op_sequencer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic [2:0]        opcode,
  input  logic              is_op,
  input  logic              is_enter,
  input  logic              elem_valid,
  input  logic [DATA_W-1:0] elem_data,
  input  logic              clear,
  output logic              busy,
  output logic [2:0]        phase,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic              done,
  output logic              ovf
);
  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        op;
  logic [DATA_W-1:0] a_mem [MAT_ELEMS];
  logic [DATA_W-1:0] b_mem [MAT_ELEMS];
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_ELEMS - 1);

  matrix_elem_alu u_alu (
    .a   (a_mem[idx]),
    .b   (b_mem[idx]),
    .sub (op == OP_SUB),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  assign phase = state;
  assign busy  = (state != ST_IDLE) && (state != ST_DONE);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op        <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      for (int i = 0; i < MAT_ELEMS; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (clear) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op        <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        ST_IDLE: if (elem_valid) begin
          a_mem[0] <= elem_data;
          idx      <= IDX_W'(1);
          ovf      <= 1'b0;
          state    <= ST_LOAD_A;
        end
        ST_LOAD_A: if (elem_valid) begin
          a_mem[idx] <= elem_data;
          idx        <= idx + IDX_W'(1);
          if (idx == LAST_IDX) state <= ST_WAIT_OP;
        end
        ST_WAIT_OP: if (is_op && is_valid_op(opcode)) begin
          op    <= opcode;
          state <= ST_LOAD_B;
        end
        ST_LOAD_B: if (elem_valid) begin
          b_mem[idx] <= elem_data;
          idx        <= idx + IDX_W'(1);
          if (idx == LAST_IDX) state <= ST_WAIT_ENTER;
        end
        // idx is 0 here, so element 0 is emitted on the is_enter edge itself.
        ST_WAIT_ENTER: if (is_enter) begin
          res_valid <= 1'b1;
          res_idx   <= idx;
          res_data  <= alu_res;
          if (alu_ovf) ovf <= 1'b1;
          idx       <= idx + IDX_W'(1);
          state     <= ST_EXEC;
        end
        // idx wrapping back to 0 marks that element 3 has already been emitted.
        ST_EXEC: begin
          if (idx == '0) begin
            state <= ST_DONE;
          end else begin
            res_valid <= 1'b1;
            res_idx   <= idx;
            res_data  <= alu_res;
            if (alu_ovf) ovf <= 1'b1;
            idx       <= idx + IDX_W'(1);
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed self-checking bench for matrix_op_sequencer.
module tb_matrix_op_sequencer;
  logic       clk = 1'b0;
  logic       nrst;
  logic [2:0] opcode;
  logic       is_op, is_enter, elem_valid, clear;
  logic [7:0] elem_data;
  logic       busy, res_valid, done, ovf;
  logic [2:0] phase;
  logic [1:0] res_idx;
  logic [7:0] res_data;

  int n_checks = 0;
  int n_fail   = 0;
  int va[4], vb[4], vr[4];
  logic [2:0] vop;
  int vovf;

  always #5 clk = ~clk;

  matrix_op_sequencer dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .is_op(is_op), .is_enter(is_enter),
    .elem_valid(elem_valid), .elem_data(elem_data), .clear(clear), .busy(busy),
    .phase(phase), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .done(done), .ovf(ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_elem(input int v);
    @(negedge clk);
    elem_data  = 8'(v);
    elem_valid = 1'b1;
    @(posedge clk);
    #1 elem_valid = 1'b0;
  endtask

  task automatic pulse_op(input logic [2:0] oc);
    @(negedge clk);
    opcode = oc;
    is_op  = 1'b1;
    @(posedge clk);
    #1 is_op = 1'b0;
  endtask

  task automatic pulse_enter();
    @(negedge clk);
    is_enter = 1'b1;
    @(posedge clk);
    #1 is_enter = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Full load/op/load/enter sequence from IDLE, checking the result stream.
  task automatic run_seq(input string t);
    for (int i = 0; i < 4; i++) pulse_elem(va[i]);
    @(negedge clk) check({t, ".wait_op"}, phase, 2);
    pulse_op(vop);
    @(negedge clk) check({t, ".load_b"}, phase, 3);
    for (int i = 0; i < 4; i++) pulse_elem(vb[i]);
    @(negedge clk) check({t, ".wait_enter"}, phase, 4);
    pulse_enter();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("%s.vld%0d", t, i), res_valid, 1);
      check($sformatf("%s.idx%0d", t, i), res_idx, i);
      check($sformatf("%s.dat%0d", t, i), res_data, vr[i] & 255);
      check($sformatf("%s.busy%0d", t, i), busy, 1);
    end
    @(negedge clk);
    check({t, ".done"}, done, 1);
    check({t, ".vld_off"}, res_valid, 0);
    check({t, ".phase_done"}, phase, 6);
    check({t, ".busy_off"}, busy, 0);
    check({t, ".ovf"}, ovf, vovf);
    check({t, ".dat_hold"}, res_data, vr[3] & 255);
    pulse_elem(9);
    pulse_op(3'b001);
    @(negedge clk) check({t, ".done_hold"}, phase, 6);
    pulse_clear();
    @(negedge clk) check({t, ".cleared"}, phase, 0);
  endtask

  initial begin
    int seen;
    nrst = 1'b0; opcode = '0; is_op = 0; is_enter = 0; elem_valid = 0;
    elem_data = '0; clear = 0;
    #12;
    check("rst.phase", phase, 0);
    check("rst.busy", busy, 0);
    check("rst.vld", res_valid, 0);
    check("rst.idx", res_idx, 0);
    check("rst.dat", res_data, 0);
    check("rst.done", done, 0);
    check("rst.ovf", ovf, 0);
    nrst = 1'b1;

    va = '{1, 2, 3, 4}; vb = '{10, 20, 30, 40}; vr = '{11, 22, 33, 44};
    vop = 3'b001; vovf = 0;
    run_seq("add");

    va = '{5, 5, 5, 5}; vb = '{7, 0, -3, 5}; vr = '{-2, 5, 8, 0};
    vop = 3'b010; vovf = 0;
    run_seq("sub");

    va = '{100, 0, 0, 0}; vb = '{100, 0, 0, 0};
`ifdef MATOP_SATURATE_EN
    vr = '{127, 0, 0, 0};
`else
    vr = '{-56, 0, 0, 0};
`endif
    vop = 3'b001; vovf = 1;
    run_seq("ovf");

    // Ignored inputs, then clear during the second EXEC cycle.
    for (int i = 0; i < 4; i++) pulse_elem(i == 0 ? 100 : 1);
    pulse_elem(9);
    @(negedge clk) check("ign.elem_wait_op", phase, 2);
    pulse_op(3'b011);
    @(negedge clk) check("ign.bad_op", phase, 2);
    pulse_op(3'b001);
    pulse_elem(100);
    pulse_elem(1);
    pulse_enter();
    @(negedge clk);
    check("ign.enter_load_b", phase, 3);
    check("ign.no_vld", res_valid, 0);
    pulse_elem(1);
    pulse_elem(1);
    pulse_enter();
    @(negedge clk) check("clr.ovf_set", ovf, 1);
    @(negedge clk);
    check("clr.cyc2_idx", res_idx, 1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clr.phase", phase, 0);
    check("clr.vld", res_valid, 0);
    check("clr.done", done, 0);
    check("clr.ovf", ovf, 0);
    check("clr.idx_hold", res_idx, 1);

    // Async reset in LOAD_B, then a fresh full sequence.
    for (int i = 0; i < 4; i++) pulse_elem(3);
    pulse_op(3'b001);
    pulse_elem(3);
    pulse_elem(3);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("rstb.phase", phase, 0);
    check("rstb.busy", busy, 0);
    check("rstb.idx", res_idx, 0);
    check("rstb.dat", res_data, 0);
    check("rstb.ovf", ovf, 0);
    @(negedge clk) nrst = 1'b1;
    va = '{1, 2, 3, 4}; vb = '{10, 20, 30, 40}; vr = '{11, 22, 33, 44};
    vop = 3'b001; vovf = 0;
    run_seq("after_rst");

    // Reset mid-EXEC truncates the stream.
    for (int i = 0; i < 4; i++) pulse_elem(1);
    pulse_op(3'b001);
    for (int i = 0; i < 4; i++) pulse_elem(1);
    pulse_enter();
    @(negedge clk) check("rste.first_vld", res_valid, 1);
    nrst = 1'b0;
    #1 check("rste.vld_now", res_valid, 0);
    @(negedge clk) nrst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("rste.no_more_vld", seen, 0);
    check("rste.phase", phase, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule

// File: doc/matrix_op_sequencer.md
MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 SHALL have: clk  input  1  system clock, rising edge.
REQ-002 SHALL have: nrst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: opcode  input  3  operation code from the keypad encoder (001 add, 010 subtract).
REQ-004 SHALL have: is_op  input  1  single-cycle strobe qualifying opcode.
REQ-005 SHALL have: is_enter  input  1  single-cycle execute strobe.
REQ-006 SHALL have: elem_valid  input  1  single-cycle strobe qualifying elem_data.
REQ-007 SHALL have: elem_data  input  8  signed two's-complement matrix element.
REQ-008 SHALL have: clear  input  1  synchronous abort/restart.
REQ-009 SHALL have: busy  output  1  high in every state except IDLE and DONE.
REQ-010 SHALL have: phase  output  3  current FSM state encoding.
REQ-011 SHALL have: res_valid  output  1  result element strobe.
REQ-012 SHALL have: res_idx  output  2  result element index, row-major.
REQ-013 SHALL have: res_data  output  8  signed result element.
REQ-014 SHALL have: done  output  1  high while in DONE.
REQ-015 SHALL have: ovf  output  1  sticky overflow flag for the current operation.

Function
REQ-016 SHALL implement states IDLE, LOAD_A, WAIT_OP, LOAD_B, WAIT_ENTER, EXEC, DONE on 2x2 matrices (4 elements each).
REQ-017 IDLE: elem_valid SHALL write A[0], set idx=1, go LOAD_A; all other inputs ignored.
REQ-018 LOAD_A/LOAD_B: each elem_valid SHALL write A[idx]/B[idx] and increment idx; the 4th write SHALL go WAIT_OP/WAIT_ENTER with idx=0.
REQ-019 WAIT_OP: is_op with opcode 001 or 010 SHALL latch the op and go LOAD_B; any other opcode SHALL be ignored.
REQ-020 is_op outside WAIT_OP, is_enter outside WAIT_ENTER, and elem_valid in WAIT_OP, WAIT_ENTER, EXEC or DONE SHALL be ignored.
REQ-021 WAIT_ENTER: is_enter SHALL go EXEC.
REQ-022 EXEC SHALL last exactly 4 cycles; res_valid high, res_idx 0,1,2,3, res_data = A[i] op B[i], all registered; first cycle is the one after the edge sampling is_enter.
REQ-023 After the last result, the FSM SHALL enter DONE, with done=1 one cycle after the final res_valid cycle; it SHALL hold until clear.
REQ-024 res_valid SHALL be 0 outside EXEC; res_idx/res_data SHALL hold their last value.
REQ-025 Arithmetic SHALL be 8-bit signed; signed overflow on any element SHALL set ovf, which stays set until clear or the next IDLE->LOAD_A transition.
REQ-026 clear SHALL take priority over every other input in any state: go IDLE, zero idx, op, ovf and done; A/B contents need not be cleared.
REQ-027 Simultaneous is_op and elem_valid in WAIT_OP SHALL act on is_op only.

Reset
REQ-028 nrst low SHALL force state IDLE, idx=0, op=0, A/B=0, and outputs busy=0, phase=IDLE, res_valid=0, res_idx=0, res_data=0, done=0, ovf=0.
REQ-029 Reset mid-EXEC SHALL truncate the result stream immediately, with no further res_valid.

Configuration
REQ-030 With MATOP_SATURATE_EN defined, an overflowed element SHALL clamp to +127 or -128; otherwise it SHALL wrap modulo 256. ovf behaves identically in both builds.

Structure
REQ-031 Package matrix_pkg SHALL hold the state enum, the OP_ADD=3'b001 and OP_SUB=3'b010 constants, DATA_W=8 and MAT_ELEMS=4.
REQ-032 A combinational sub-module matrix_elem_alu SHALL compute one element's add/sub, its overflow, and the optional saturation; it is instantiated once and time-shared over the 4 EXEC cycles.

Verification
REQ-033 Load A={1,2,3,4}, op 001, B={10,20,30,40}, is_enter -> res_valid 4 cycles, res_data 11,22,33,44, done next cycle, ovf=0.
REQ-034 Load A={5,5,5,5}, op 010, B={7,0,-3,5} -> results -2,5,8,0.
REQ-035 Load A={100,0,0,0}, op 001, B={100,0,0,0} -> element 0 = -56 (wrap) or 127 (MATOP_SATURATE_EN); ovf=1 in both builds.
REQ-036 is_op with opcode 011 in WAIT_OP, then is_enter in LOAD_B after 2 elements -> state unchanged both times; no res_valid.
REQ-037 clear asserted in EXEC cycle 2 -> next cycle IDLE, res_valid=0, done=0, ovf=0.
REQ-038 nrst pulsed low in LOAD_B -> all outputs at reset values; a fresh full sequence then completes correctly.
